doy_entry_ctrl: RTL and testbench

//   Front-end input stage that feeds monthDayCalc. It debounces the two push buttons and

---
 rtl/doy_entry_ctrl.sv | 172 +++++++++++++++++
 tb/tb_doy_entry_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/doy_entry_ctrl.sv
// rtl/doy_entry_ctrl.sv - debounced three-digit day-of-year entry with range validation
module doy_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_n,
   input  logic [9:0] sw,
   output logic [3:0] dig_h,
   output logic [3:0] dig_t,
   output logic [3:0] dig_o,
   output logic [8:0] doy,
   output logic       leap,
   output logic       doy_valid,
   output logic       doy_load,
   output logic       entry_err,
   output logic [1:0] entry_pos
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {S_HUND, S_TENS, S_ONES, S_DONE, S_ERR} state_t;

   logic [1:0]       sync1_q, sync2_q, stable_q, press_q;
   logic [CNT_W-1:0] cnt_q [2];

   // Stable value flips only after CNT_MAX+1 consecutive differing samples; any bounce restarts.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         stable_q <= 2'b11;
         press_q  <= 2'b00;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         for (int k = 0; k < 2; k++) begin
            press_q[k] <= 1'b0;
            if (sync2_q[k] == stable_q[k]) begin
               cnt_q[k] <= '0;
            end else if (cnt_q[k] == CNT_MAX) begin
               stable_q[k] <= sync2_q[k];
               cnt_q[k]    <= '0;
               press_q[k]  <= ~sync2_q[k];
            end else begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   logic acc, clr;
   assign acc = press_q[0];
   assign clr = press_q[1];

   state_t     state_q, state_d;
   logic [3:0] dig_h_q, dig_h_d, dig_t_q, dig_t_d, dig_o_q, dig_o_d;
   logic [8:0] doy_q, doy_d;
   logic       leap_q, leap_d;
   logic       valid_q, valid_d, load_q, load_d, err_q, err_d;
   logic [1:0] pos_q, pos_d;

   logic [3:0] digit;
   logic [8:0] doy_calc, day_max;
   logic       sw_unused;

   assign digit     = sw[3:0];
   assign sw_unused = ^sw[8:4];
   // Range check uses the incoming ones digit, not the registered one.
   assign doy_calc  = 9'(dig_h_q) * 9'd100 + 9'(dig_t_q) * 9'd10 + 9'(digit);
   assign day_max   = sw[9] ? 9'd366 : 9'd365;

   always_comb begin
      state_d = state_q;
      dig_h_d = dig_h_q;
      dig_t_d = dig_t_q;
      dig_o_d = dig_o_q;
      doy_d   = doy_q;
      leap_d  = leap_q;
      if (clr) begin
         state_d = S_HUND;
         dig_h_d = 4'd0;
         dig_t_d = 4'd0;
         dig_o_d = 4'd0;
         doy_d   = 9'd0;
         leap_d  = 1'b0;
      end else if (acc) begin
         case (state_q)
            S_HUND: begin
               if (digit <= 4'd3) begin
                  dig_h_d = digit;
                  state_d = S_TENS;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_TENS: begin
               if (digit <= 4'd9) begin
                  dig_t_d = digit;
                  state_d = S_ONES;
               end else begin
                  state_d = S_ERR;
               end
            end
            S_ONES: begin
               if (digit <= 4'd9) begin
                  dig_o_d = digit;
                  leap_d  = sw[9];
                  doy_d   = doy_calc;
                  if (doy_calc >= 9'd1 && doy_calc <= day_max) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ERR;
                  end
               end else begin
                  state_d = S_ERR;
               end
            end
            default: state_d = state_q;
         endcase
      end
      valid_d = (state_d == S_DONE);
      load_d  = (state_d == S_DONE) && (state_q != S_DONE);
      err_d   = (state_d == S_ERR);
      case (state_d)
         S_HUND:  pos_d = 2'd0;
         S_TENS:  pos_d = 2'd1;
         S_ONES:  pos_d = 2'd2;
         default: pos_d = 2'd3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_HUND;
         dig_h_q <= 4'd0;
         dig_t_q <= 4'd0;
         dig_o_q <= 4'd0;
         doy_q   <= 9'd0;
         leap_q  <= 1'b0;
         valid_q <= 1'b0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
         pos_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         dig_h_q <= dig_h_d;
         dig_t_q <= dig_t_d;
         dig_o_q <= dig_o_d;
         doy_q   <= doy_d;
         leap_q  <= leap_d;
         valid_q <= valid_d;
         load_q  <= load_d;
         err_q   <= err_d;
         pos_q   <= pos_d;
      end
   end

   assign dig_h     = dig_h_q;
   assign dig_t     = dig_t_q;
   assign dig_o     = dig_o_q;
   assign doy       = doy_q;
   assign leap      = leap_q;
   assign doy_valid = valid_q;
   assign doy_load  = load_q;
   assign entry_err = err_q;
   assign entry_pos = pos_q;

endmodule

// File: tb/tb_doy_entry_ctrl.sv
// tb/tb_doy_entry_ctrl.sv - randomized bench for doy_entry_ctrl against a behavioural model
module tb_doy_entry_ctrl;
   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] key_n;
   logic [9:0] sw;
   logic [3:0] dig_h, dig_t, dig_o;
   logic [8:0] doy;
   logic       leap, doy_valid, doy_load, entry_err;
   logic [1:0] entry_pos;

   doy_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .sw(sw),
      .dig_h(dig_h), .dig_t(dig_t), .dig_o(dig_o), .doy(doy), .leap(leap),
      .doy_valid(doy_valid), .doy_load(doy_load), .entry_err(entry_err),
      .entry_pos(entry_pos)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int load_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: entry position, committed values, and a key-sample history delayed by the synchronizer.
   int         m_h = 0, m_t = 0, m_o = 0, m_doy = 0, m_leap = 0;
   int         m_valid = 0, m_load = 0, m_err = 0, m_pos = 0;
   bit         m_press [2];
   bit         m_stable [2];
   int         m_run [2];
   logic [1:0] hist [$];
   logic [1:0] ev;
   int         d, sum;

   always @(posedge clk) begin
      if (rst) begin
         m_h = 0; m_t = 0; m_o = 0; m_doy = 0; m_leap = 0;
         m_valid = 0; m_load = 0; m_err = 0; m_pos = 0;
         hist = '{2'b11, 2'b11};
         for (int k = 0; k < 2; k++) begin
            m_press[k] = 0; m_stable[k] = 1; m_run[k] = 0;
         end
      end else begin
         m_load = 0;
         d = int'(sw[3:0]);
         if (m_press[1]) begin
            m_h = 0; m_t = 0; m_o = 0; m_doy = 0; m_leap = 0;
            m_valid = 0; m_err = 0; m_pos = 0;
         end else if (m_press[0] && m_pos < 3) begin
            if (m_pos == 0 && d <= 3) begin
               m_h = d; m_pos = 1;
            end else if (m_pos == 1 && d <= 9) begin
               m_t = d; m_pos = 2;
            end else if (m_pos == 2 && d <= 9) begin
               m_o = d; m_leap = sw[9];
               sum = m_h * 100 + m_t * 10 + d;
               m_doy = sum; m_pos = 3;
               if (sum >= 1 && sum <= (m_leap ? 366 : 365)) begin
                  m_valid = 1; m_load = 1;
               end else begin
                  m_err = 1;
               end
            end else begin
               m_err = 1; m_pos = 3;
            end
         end
         hist.push_back(key_n);
         ev = hist.pop_front();
         for (int k = 0; k < 2; k++) begin
            m_press[k] = 0;
            if (ev[k] != m_stable[k]) begin
               m_run[k]++;
               if (m_run[k] == DEB) begin
                  m_stable[k] = ev[k];
                  m_run[k] = 0;
                  m_press[k] = !ev[k];
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("dig_h", dig_h, m_h);
      check("dig_t", dig_t, m_t);
      check("dig_o", dig_o, m_o);
      check("doy", doy, m_doy);
      check("leap", leap, m_leap);
      check("doy_valid", doy_valid, m_valid);
      check("doy_load", doy_load, m_load);
      check("entry_err", entry_err, m_err);
      check("entry_pos", entry_pos, m_pos);
      if (doy_load) load_cnt++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int k);
      key_n[k] = 1'b0;
      cycles(DEB + 6);
      key_n[k] = 1'b1;
      cycles(DEB + 4);
   endtask

   task automatic digit(input int dv, input bit lp);
      sw = {lp, 5'($urandom), 4'(dv)};
      press(0);
      sw = 10'($urandom);
   endtask

   task automatic clear();
      press(1);
   endtask

   initial begin
      rst = 1'b1;
      key_n = 2'b11;
      sw = 10'd0;
      cycles(3);
      check("rst_pos", entry_pos, 0);
      check("rst_valid", doy_valid, 0);
      rst = 1'b0;
      cycles(2);

      // T1
      load_cnt = 0;
      digit(0, 0); digit(6, 0); digit(0, 0);
      check("t1_doy", doy, 60);
      check("t1_dig_t", dig_t, 6);
      check("t1_valid", doy_valid, 1);
      check("t1_err", entry_err, 0);
      check("t1_loads", load_cnt, 1);
      digit(1, 0);
      check("t1_ignored", doy, 60);

      // T2
      clear(); digit(3, 1); digit(6, 1); digit(6, 1);
      check("t2_doy", doy, 366);
      check("t2_valid", doy_valid, 1);
      clear(); digit(3, 0); digit(6, 0); digit(6, 0);
      check("t2_err", entry_err, 1);
      check("t2_valid0", doy_valid, 0);

      // T3
      clear(); digit(4, 0);
      check("t3_pos", entry_pos, 3);
      check("t3_err", entry_err, 1);
      digit(2, 0);
      check("t3_hold", dig_h, 0);
      clear();
      check("t3_clr_pos", entry_pos, 0);
      check("t3_clr_err", entry_err, 0);

      // T4
      sw = 10'd2;
      for (int i = 0; i < 10; i++) begin
         key_n[0] = ~key_n[0];
         cycles(2);
      end
      key_n[0] = 1'b0;
      cycles(40);
      key_n[0] = 1'b1;
      cycles(DEB + 4);
      check("t4_dig_h", dig_h, 2);
      check("t4_pos", entry_pos, 1);

      // T5
      clear(); digit(0, 0); digit(0, 0); digit(0, 0);
      check("t5_err", entry_err, 1);
      clear(); digit(3, 0); digit(6, 0); digit(5, 0);
      check("t5_doy", doy, 365);
      check("t5_valid", doy_valid, 1);

      // T6
      clear(); digit(1, 0); digit(2, 0);
      key_n = 2'b00;
      cycles(DEB + 6);
      key_n = 2'b11;
      cycles(DEB + 4);
      check("t6_both_pos", entry_pos, 0);
      check("t6_both_h", dig_h, 0);
      digit(1, 0); digit(2, 0);
      check("t6_pre_pos", entry_pos, 2);
      rst = 1'b1;
      cycles(1);
      check("t6_rst_pos", entry_pos, 0);
      check("t6_rst_t", dig_t, 0);
      rst = 1'b0;
      cycles(2);

      // Randomized phase
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: digit($urandom_range(0, 9), 1'($urandom));
            6: digit($urandom_range(0, 15), 1'($urandom));
            7: clear();
            8: begin
               sw = 10'($urandom);
               repeat ($urandom_range(2, 6)) begin
                  key_n[0] = ~key_n[0];
                  cycles($urandom_range(1, DEB + 2));
               end
               key_n = 2'b11;
               cycles(DEB + 4);
            end
            default: begin
               key_n[0] = 1'b0;
               cycles($urandom_range(1, DEB + 1));
               rst = 1'b1;
               cycles(1);
               rst = 1'b0;
               cycles(DEB + 6);
               key_n = 2'b11;
               cycles(DEB + 4);
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
